// File: rtl/truth_table_scanner_pkg.sv
// Shared types and widths for the truth-table scanner.
// FSM encoding and result bus sizes live here.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int IDX_W   = 4;
  localparam int TABLE_W = 16;
  localparam int COUNT_W = 5;
  localparam int CNT_W   = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd15;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Stimulus/readback bundle between the scanner
// and its requester / function under test.
interface truth_table_scanner_if;
  import truth_table_scanner_pkg::*;

  logic               start;
  logic               f_sop;
  logic               f_pos;
  logic               x;
  logic               y;
  logic               w;
  logic               z;
  logic               busy;
  logic               done;
  logic [TABLE_W-1:0] table_sop;
  logic [TABLE_W-1:0] table_pos;
  logic [COUNT_W-1:0] minterm_count;
  logic               mismatch;
  logic [IDX_W-1:0]   first_mismatch;

  modport master (
    output start,
    output f_sop,
    output f_pos,
    input  x,
    input  y,
    input  w,
    input  z,
    input  busy,
    input  done,
    input  table_sop,
    input  table_pos,
    input  minterm_count,
    input  mismatch,
    input  first_mismatch
  );

  modport slave (
    input  start,
    input  f_sop,
    input  f_pos,
    output x,
    output y,
    output w,
    output z,
    output busy,
    output done,
    output table_sop,
    output table_pos,
    output minterm_count,
    output mismatch,
    output first_mismatch
  );

endinterface

// File: rtl/truth_table_scanner_settle_counter.sv
// Settle-time counter: clear, enable, and a
// terminal flag when the count hits SETTLE_CYCLES-1.
module truth_table_scanner_settle_counter
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL =
    CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 16 input vectors, samples SOP/POS
// outputs and accumulates tables, count, mismatch.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_scanner_if.slave bus
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TABLE_W-1:0] r_tsop;
  logic [TABLE_W-1:0] r_tpos;
  logic [COUNT_W-1:0] r_cnt;
  logic               r_mis;
  logic [IDX_W-1:0]   r_first;
  logic               r_busy;
  logic               r_done;

  logic w_accept;
  logic w_clr;
  logic w_en;
  logic w_tc;

  assign w_accept = bus.start &&
    (r_state == IDLE || r_state == DONE);
  assign w_clr = w_accept || (r_state == SAMPLE);
  assign w_en  = (r_state == SETTLE);

  truth_table_scanner_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .i_clear(w_clr),
    .i_en   (w_en),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_tsop  <= '0;
      r_tpos  <= '0;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
      r_first <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= SETTLE;
            r_idx   <= '0;
            r_tsop  <= '0;
            r_tpos  <= '0;
            r_cnt   <= '0;
            r_mis   <= 1'b0;
            r_first <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        SETTLE: begin
          if (w_tc) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_tsop[r_idx] <= bus.f_sop;
          r_tpos[r_idx] <= bus.f_pos;
          r_cnt <= r_cnt +
            {{(COUNT_W-1){1'b0}}, bus.f_sop};
          if (bus.f_sop != bus.f_pos && !r_mis) begin
            r_mis   <= 1'b1;
            r_first <= r_idx;
          end
          // Stimulus parks at 0 once the scan ends.
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.x              = r_idx[3];
  assign bus.y              = r_idx[2];
  assign bus.w              = r_idx[1];
  assign bus.z              = r_idx[0];
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.table_sop      = r_tsop;
  assign bus.table_pos      = r_tpos;
  assign bus.minterm_count  = r_cnt;
  assign bus.mismatch       = r_mis;
  assign bus.first_mismatch = r_first;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench: two scanners (settle 1 and 3) driving a
// table-lookup function, checked against a model.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] sop_tab = 16'h0;
  logic [15:0] pos_tab = 16'h0;
  int checks = 0;
  int errors = 0;

  truth_table_scanner_if if1 ();
  truth_table_scanner_if if3 ();

  truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (if1.slave)
  );

  truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (if3.slave)
  );

  always #5 clk = ~clk;

  assign if1.f_sop = sop_tab[{if1.x, if1.y, if1.w, if1.z}];
  assign if1.f_pos = pos_tab[{if1.x, if1.y, if1.w, if1.z}];
  assign if3.f_sop = sop_tab[{if3.x, if3.y, if3.w, if3.z}];
  assign if3.f_pos = pos_tab[{if3.x, if3.y, if3.w, if3.z}];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack1();
    return {if1.x, if1.y, if1.w, if1.z, if1.busy,
            if1.done, if1.table_sop, if1.table_pos,
            if1.minterm_count, if1.mismatch,
            if1.first_mismatch};
  endfunction

  function automatic logic [47:0] pack3();
    return {if3.x, if3.y, if3.w, if3.z, if3.busy,
            if3.done, if3.table_sop, if3.table_pos,
            if3.minterm_count, if3.mismatch,
            if3.first_mismatch};
  endfunction

  // Full scan on both DUTs; optional extra start mid-scan.
  task automatic run_scan(input string tag,
                          input logic [15:0] s,
                          input logic [15:0] p,
                          input bit restart);
    int bad1 = 0;
    int bad3 = 0;
    int exp_cnt;
    logic exp_mis;
    logic [3:0] exp_first;
    sop_tab = s;
    pos_tab = p;
    exp_cnt = $countones(s);
    exp_mis = 1'b0;
    exp_first = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (s[i] != p[i] && !exp_mis) begin
        exp_mis = 1'b1;
        exp_first = 4'(i);
      end
    end
    @(negedge clk);
    if1.start = 1'b1;
    if3.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if3.start = 1'b0;
    chk({tag, " start_clear1"},
        {46'd0, if1.busy, if1.done,
         if1.table_sop, if1.minterm_count, if1.mismatch},
        {46'd0, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0});
    for (int k = 0; k <= 64; k++) begin
      if (k < 32) begin
        if ({if1.x, if1.y, if1.w, if1.z} != 4'(k / 2) ||
            if1.done !== 1'b0 || if1.busy !== 1'b1)
          bad1++;
      end else if ({if1.x, if1.y, if1.w, if1.z} != 4'd0 ||
                   if1.done !== 1'b1 || if1.busy !== 1'b0)
        bad1++;
      if (k < 64) begin
        if ({if3.x, if3.y, if3.w, if3.z} != 4'(k / 4) ||
            if3.done !== 1'b0 || if3.busy !== 1'b1)
          bad3++;
      end else if (if3.done !== 1'b1 || if3.busy !== 1'b0)
        bad3++;
      if (restart && k == 10) begin
        if1.start = 1'b1;
        if3.start = 1'b1;
      end
      if (restart && k == 11) begin
        if1.start = 1'b0;
        if3.start = 1'b0;
      end
      if (k < 64) @(negedge clk);
    end
    chk({tag, " seq_timing1"}, 64'(bad1), 64'd0);
    chk({tag, " seq_timing3"}, 64'(bad3), 64'd0);
    chk({tag, " result1"},
        {if1.table_sop, if1.table_pos,
         11'(if1.minterm_count), 1'(if1.mismatch),
         4'(if1.first_mismatch)},
        {s, p, 11'(exp_cnt), exp_mis, exp_first});
    chk({tag, " result3"},
        {if3.table_sop, if3.table_pos,
         11'(if3.minterm_count), 1'(if3.mismatch),
         4'(if3.first_mismatch)},
        {s, p, 11'(exp_cnt), exp_mis, exp_first});
  endtask

  initial begin
    int waited;
    logic [15:0] rs;
    logic [15:0] rp;
    if1.start = 1'b0;
    if3.start = 1'b0;
    #1;
    chk("reset1", 64'(pack1()), 64'd0);
    chk("reset3", 64'(pack3()), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle1", 64'(pack1()), 64'd0);

    run_scan("equal", 16'h9527, 16'h9527, 1'b1);
    run_scan("diff", 16'h9527, 16'hFE97, 1'b0);
    run_scan("ones", 16'hFFFF, 16'hFFFF, 1'b0);
    run_scan("zeros", 16'h0000, 16'h0000, 1'b0);
    run_scan("hi_mis", 16'h0000, 16'h8000, 1'b0);
    for (int n = 0; n < 4; n++) begin
      rs = 16'($urandom);
      rp = (n[0]) ? rs : 16'($urandom);
      run_scan("rand", rs, rp, n == 2);
    end

    rs = 16'($urandom) | 16'h0001;
    sop_tab = rs;
    pos_tab = ~rs;
    @(negedge clk);
    if1.start = 1'b1;
    if3.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if3.start = 1'b0;
    waited = 0;
    while ({if1.x, if1.y, if1.w, if1.z} != 4'd7 &&
           waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("reach_idx7", 64'(waited < 200), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset1", 64'(pack1()), 64'd0);
    chk("midreset3", 64'(pack3()), 64'd0);
    @(negedge clk);
    chk("reset_hold1", 64'(pack1()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    rp = 16'($urandom);
    run_scan("after_reset", rs, rp, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequential stimulus/readback engine for 4-input combinational function blocks. On a start pulse it drives all 16 combinations of x,y,w,z in order and samples the block's SOP and POS outputs. It assembles both 16-bit truth tables, counts minterms, and flags any SOP/POS disagreement. It sits on the driving side of any SOP/POS function module, feeding its inputs and consuming its f_sop/f_pos outputs.

Parameters:
SETTLE_CYCLES, 1, cycles each input vector is held before sampling (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a scan; ignored while busy
f_sop  input  1  SOP output of function under test
f_pos  input  1  POS output of function under test
x  output  1  stimulus MSB, index bit 3
y  output  1  stimulus, index bit 2
w  output  1  stimulus, index bit 1
z  output  1  stimulus LSB, index bit 0
busy  output  1  high while a scan is in progress
done  output  1  high from scan completion until next accepted start
table_sop  output  16  bit i = f_sop sampled at index i
table_pos  output  16  bit i = f_pos sampled at index i
minterm_count  output  5  number of 1s in table_sop (0..16)
mismatch  output  1  sticky: some index had f_sop != f_pos
first_mismatch  output  4  lowest index with disagreement; 0 when mismatch=0

Behaviour:
- Reset (async, immediate): state=IDLE; idx, settle counter, and all outputs are 0, including x,y,w,z, tables, count, mismatch, done, and busy.
- Stimulus mapping: {x,y,w,z} = idx. Outputs are registered, so they change only on clk edges.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 moves to SETTLE with idx=0, settle counter=0, busy=1, and done=0. Tables, count, mismatch, and first_mismatch clear on the same edge.
- SETTLE: the counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle): on the exiting edge, table_sop[idx]<=f_sop and table_pos[idx]<=f_pos.
  - minterm_count increments if f_sop=1.
  - If f_sop!=f_pos and mismatch=0, set mismatch=1 and first_mismatch=idx.
  - If idx==15, go to DONE. Otherwise idx<=idx+1, counter<=0, and return to SETTLE.
- DONE: busy=0 and done=1. x,y,w,z return to 0. Results hold until the next start.
- start in DONE behaves exactly as in IDLE: a new scan begins and results clear. start is ignored in SETTLE and SAMPLE.
- Latency: a start accepted at edge N gives done=1 after edge N+16*(SETTLE_CYCLES+1). With default SETTLE_CYCLES=1, that is 32 cycles.
- Each vector is stable for SETTLE_CYCLES+1 cycles before its sample edge.
- idx never wraps past 15. minterm_count saturates naturally at 16 (5 bits, no overflow).
- Reset asserted mid-scan aborts immediately to IDLE with all outputs 0. No partial results are retained.
- The module does not check f_sop/f_pos for X. The bench must keep them driven.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3), IDX_W=4, TABLE_W=16, COUNT_W=5.
- Natural sub-module: settle_counter (load/clear, enable, terminal-count flag at SETTLE_CYCLES-1). FSM, index register, and result accumulation stay in the top.

Test Plan:
- Bench model f_sop=table 16'h9527[idx], f_pos=16'h9527[idx]; pulse start → after 32 cycles done=1, table_sop=table_pos=16'h9527, minterm_count=8, mismatch=0, first_mismatch=0.
- Bench model f_sop=16'h9527[idx], f_pos=16'hFE97[idx] → table_pos=16'hFE97, mismatch=1, first_mismatch=4, minterm_count=8.
- Constant f_sop=f_pos=1 → minterm_count=16, tables=16'hFFFF. Constant 0 → count=0, tables=16'h0000.
- Monitor {x,y,w,z} during a scan → sequence 0..15 in order, each held exactly SETTLE_CYCLES+1 cycles. Repeat with SETTLE_CYCLES=3: done at 64 cycles after start.
- start pulsed again at cycle 10 of a scan → ignored: scan completes on original schedule, results unchanged. start in DONE → results clear and a new scan runs.
- Assert reset asynchronously at idx=7 → all outputs 0 immediately, FSM in IDLE. A following start produces a full, correct scan.
